// File: rtl/shared_arb_pkg.sv
// rtl/shared_arb_pkg.sv - shared arbitration types, widths and helpers
package shared_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Minimum of 1 so that a single-entry field still gets a real bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_N   = 8;
  localparam int DEF_IDW = clog2(DEF_N);

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at or after ptr
module rr_pick
  import shared_arb_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx,
  output logic [N-1:0]   onehot
);

  logic [N-1:0] rot;
  int           off;
  int           sum;

  always_comb begin
    rot    = '0;
    off    = 0;
    sum    = 0;
    idx    = '0;
    onehot = '0;
    // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
    for (int i = 0; i < N; i++) begin
      sum = i + int'(ptr);
      if (sum >= N) sum = sum - N;
      rot[i] = req[sum];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    found = |rot;
    sum   = off + int'(ptr);
    if (sum >= N) sum = sum - N;
    if (found) begin
      idx         = IDW'(sum);
      onehot[sum] = 1'b1;
    end
  end

endmodule

// File: rtl/shared_resource_lease_ctrl.sv
// rtl/shared_resource_lease_ctrl.sv - lease-based round-robin owner of a shared resource
module shared_resource_lease_ctrl
  import shared_arb_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int MAX_HOLD   = 4,
  parameter int TURNAROUND = 1,
  parameter int IDW        = clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   request,
  input  logic [N-1:0]   lease_release,
  input  logic           res_ready,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] owner_id,
  output logic           timeout,
  output logic [IDW-1:0] timeout_id
);

  localparam int             HCW      = clog2(MAX_HOLD + 1);
  localparam int             GCW      = clog2(TURNAROUND + 1);
  localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
  localparam logic [GCW-1:0] GAP_MAX  = GCW'(TURNAROUND);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(N - 1);

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [HCW-1:0] hold_cnt;
  logic [GCW-1:0] gap_cnt;

  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic [N-1:0]   pick_onehot;
  logic           end_normal;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .req    (request),
    .ptr    (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Release or request-drop by the owner wins over the hold limit: no timeout then.
  assign end_normal = lease_release[owner_id] | ~request[owner_id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      owner_id    <= '0;
      timeout     <= 1'b0;
      timeout_id  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found && res_ready) begin
            grant       <= pick_onehot;
            grant_valid <= 1'b1;
            owner_id    <= pick_idx;
            hold_cnt    <= HCW'(1);
            state       <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (end_normal || hold_cnt == HOLD_MAX) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            owner_id    <= '0;
            rr_ptr      <= (owner_id == LAST_ID) ? '0 : owner_id + 1'b1;
            gap_cnt     <= GCW'(1);
            state       <= ST_GAP;
            if (!end_normal) begin
              timeout    <= 1'b1;
              timeout_id <= owner_id;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_MAX) state <= ST_IDLE;
          else                    gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_resource_lease_ctrl.sv
// tb/tb_shared_resource_lease_ctrl.sv - randomized and directed bench with a lease reference model
module tb_shared_resource_lease_ctrl;

  localparam int N          = 8;
  localparam int MAX_HOLD   = 4;
  localparam int TURNAROUND = 1;
  localparam int IDW        = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   request;
  logic [N-1:0]   lease_release;
  logic           res_ready;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] owner_id;
  logic           timeout;
  logic [IDW-1:0] timeout_id;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the resource, for how long, and how many gap cycles remain.
  int m_owner;
  int m_held;
  int m_gap;
  int m_ptr;
  bit m_to;
  int m_tid;

  shared_resource_lease_ctrl #(
    .N          (N),
    .MAX_HOLD   (MAX_HOLD),
    .TURNAROUND (TURNAROUND),
    .IDW        (IDW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .request       (request),
    .lease_release (lease_release),
    .res_ready     (res_ready),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .owner_id      (owner_id),
    .timeout       (timeout),
    .timeout_id    (timeout_id)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_gap   = 0;
    m_ptr   = 0;
    m_to    = 1'b0;
    m_tid   = 0;
  endtask

  task automatic model_step(input logic [N-1:0] rq, input logic [N-1:0] rl, input logic rdy);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (rl[m_owner] || !rq[m_owner] || m_held == MAX_HOLD) begin
        m_to    = !(rl[m_owner] || !rq[m_owner]);
        m_tid   = m_owner;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = TURNAROUND;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (rq != 0 && rdy) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && rq[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
      m_held = 1;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_grant;
    exp_grant = '0;
    if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
    check_eq("grant", grant, exp_grant);
    check_eq("grant_valid", grant_valid, m_owner >= 0);
    check_eq("owner_id", owner_id, (m_owner >= 0) ? m_owner : 0);
    check_eq("timeout", timeout, m_to);
    if (m_to) check_eq("timeout_id", timeout_id, m_tid);
    check_eq("onehot0", $onehot0(grant), 1);
  endtask

  task automatic cycle(input logic [N-1:0] rq, input logic [N-1:0] rl, input logic rdy);
    @(negedge clk);
    check_outputs();
    request       = rq;
    lease_release = rl;
    res_ready     = rdy;
    @(posedge clk);
    model_step(rq, rl, rdy);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_grant"}, grant, 0);
    check_eq({tag, "_grant_valid"}, grant_valid, 0);
    check_eq({tag, "_owner_id"}, owner_id, 0);
    check_eq({tag, "_timeout"}, timeout, 0);
    check_eq({tag, "_timeout_id"}, timeout_id, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    request       = '0;
    lease_release = '0;
    res_ready     = 1'b1;
    model_reset();
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Release on the owner's n-th grant cycle, as tracked by the model.
  function automatic logic [N-1:0] rel_on(input int nth);
    logic [N-1:0] r;
    r = '0;
    if (m_owner >= 0 && m_held == nth) r[m_owner] = 1'b1;
    return r;
  endfunction

  initial begin
    logic [N-1:0] req_r;
    logic [N-1:0] rel_r;
    int           to_seen;

    rst_n         = 1'b0;
    request       = '0;
    lease_release = '0;
    res_ready     = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    apply_reset();

    // Single persistent requester: hold limit, timeout, gap, re-grant.
    to_seen = 0;
    for (int c = 0; c < 16; c++) begin
      cycle(8'h01, 8'h00, 1'b1);
      #1;
      if (timeout) to_seen++;
    end
    check_eq("t1_timeouts", to_seen, 2);

    apply_reset();
    for (int c = 0; c < 20; c++) cycle(8'h0B, rel_on(2), 1'b1);

    apply_reset();
    for (int c = 0; c < 40; c++) cycle(8'hFF, rel_on(1), 1'b1);

    // One-cycle request at an idle edge, then pointer must be back at 0.
    apply_reset();
    cycle(8'h80, 8'h00, 1'b1);
    for (int c = 0; c < 5; c++) cycle(8'h00, 8'h00, 1'b1);
    for (int c = 0; c < 6; c++) cycle(8'h81, rel_on(1), 1'b1);

    // Resource not ready, then release coinciding with the hold limit.
    apply_reset();
    for (int c = 0; c < 5; c++) cycle(8'h03, 8'h00, 1'b0);
    for (int c = 0; c < 16; c++) cycle(8'h03, rel_on(4), 1'b1);

    // Asynchronous reset in the middle of a lease.
    apply_reset();
    for (int c = 0; c < 3; c++) cycle(8'h04, 8'h00, 1'b1);
    check_eq("t6_pre_grant", grant, 8'h04);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    request = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) cycle(8'hFF, 8'h00, 1'b1);

    // Randomized traffic with sticky requests and sporadic releases.
    apply_reset();
    req_r = '0;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) req_r[b] = ~req_r[b];
      end
      rel_r = '0;
      if ($urandom_range(0, 3) == 0) rel_r[$urandom_range(0, N - 1)] = 1'b1;
      if (m_owner >= 0 && $urandom_range(0, 4) == 0) rel_r[m_owner] = 1'b1;
      cycle(req_r, rel_r, $urandom_range(0, 4) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shared_resource_lease_ctrl.md
Name: shared_resource_lease_ctrl

Overview:
Lease-based round-robin controller that grants one of N requesters exclusive ownership of the shared resource for a bounded interval. It sits in front of the resource, next to the request/grant fabric. It adds three things over a plain per-cycle round-robin grant: a held lease with explicit release, a hold-time limit with timeout reporting, and a turnaround gap between owners. The block also gates new grants on the resource's readiness.

Parameters:
N, 8, number of requesters (≥2)
MAX_HOLD, 4, maximum consecutive cycles one lease may hold grant (≥1)
TURNAROUND, 1, idle cycles with grant=0 between consecutive leases (≥1)
IDW, $clog2(N), width of owner index outputs

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
request  input  N  per-requester level request
release  input  N  per-requester one-cycle lease release pulse
res_ready  input  1  resource can accept a new owner
grant  output  N  one-hot registered grant, or all zero
grant_valid  output  1  OR of grant
owner_id  output  IDW  index of current owner; 0 when no grant
timeout  output  1  one-cycle pulse: lease revoked by MAX_HOLD
timeout_id  output  IDW  index of revoked owner, valid with timeout

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset (async, immediate) forces:
  - grant=0, grant_valid=0, owner_id=0, timeout=0, timeout_id=0
  - state=IDLE, rr_ptr=0, hold_cnt=0, gap_cnt=0
- The same values apply when reset is asserted mid-lease. No timeout is reported for a lease killed by reset.
- FSM states: IDLE, OWNED, GAP. All outputs are registered.
- IDLE:
  - At a posedge with |request and res_ready=1, pick the first set request bit at or after rr_ptr, searching upward with wrap-around.
  - grant goes high after that edge. Latency from request to grant is 1 cycle. Set hold_cnt=1 and go to OWNED.
  - If res_ready=0, stay in IDLE with no grant.
  - Requests are sampled only in IDLE. A one-cycle request seen at that edge is still granted.
- OWNED: lease ends at the first posedge where any of these holds:
  - (a) release[owner]=1
  - (b) request[owner]=0
  - (c) hold_cnt==MAX_HOLD
- On lease end:
  - grant goes 0 after that edge.
  - rr_ptr = owner+1 mod N.
  - gap_cnt=1, go to GAP.
  - Case (c) only: timeout=1 and timeout_id=owner for exactly one cycle after that edge.
  - Otherwise hold_cnt increments, and grant is never high for more than MAX_HOLD cycles.
- Priority on simultaneous conditions: (a) or (b) together with (c) counts as a normal end, with no timeout.
- release/request from non-owners are ignored in OWNED and GAP.
- A release pulse while in IDLE or GAP is ignored.
- GAP: grant=0 for TURNAROUND cycles. When gap_cnt==TURNAROUND, go to IDLE. In IDLE, arbitration happens at the next edge.
- With a single persistent requester, the pointer wraps and the same requester is re-granted after the gap.
- res_ready dropping during OWNED has no effect on the current lease.
- Invariant: $onehot0(grant) at all times.

Decomposition:
- Shared package/header shared_arb_pkg:
  - state encodings ST_IDLE, ST_OWNED, ST_GAP
  - clog2 helper function
  - grant-width localparams
- Sub-module rr_pick (combinational):
  - inputs: req[N], ptr[IDW]
  - outputs: found, idx[IDW], onehot[N]
  - implemented as rotate + priority encode + rotate back; reusable by the existing arbiter.

Test Plan:
All tests use N=8, MAX_HOLD=4, TURNAROUND=1, res_ready=1 unless stated.
1. request=8'h01 held, no release → grant=8'h01 for 4 cycles; timeout=1, timeout_id=0 for 1 cycle; grant=0 for 1 cycle; grant=8'h01 again.
2. request=8'b0000_1011 held, owner pulses release on 2nd grant cycle → grant sequence 8'h01,8'h02,8'h08,8'h01; each lease 2 cycles, 1 gap cycle; timeout never asserted.
3. request=8'hFF held, release on 1st grant cycle → owner_id 0,1,…,7,0; exactly one grant bit ever set.
4. request=8'h80 for one cycle coinciding with an IDLE edge, then 0 → grant=8'h80 for 1 cycle, drops (request-drop end), no timeout, rr_ptr=0.
5. request=8'h03, res_ready=0 for 5 cycles then 1 → grant stays 0 for those 5 cycles; grant=8'h01 one cycle after res_ready rises. Simultaneous release and hold_cnt==4 → no timeout.
6. rst_n driven low asynchronously mid-lease (grant=8'h04) → grant=0 immediately, no timeout. After release of reset with request=8'hFF → first grant=8'h01.
